// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - Self-synchronising receive checker for the 8-bit LFSR pattern (optional bit-error counter: LFSR_CHK_BITCNT_EN)
module lfsr_checker #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [7:0]       i_data,
    input  logic             i_soft_reset,
    output logic             o_lock,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_count
`ifdef LFSR_CHK_BITCNT_EN
    ,
    output logic [CNT_W-1:0] o_bit_err_count
`endif
);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [3:0] LOCK_CNT_L   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_CNT_L = 4'(UNLOCK_CNT);

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB with feedback into bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    state_e             state_q, state_d;
    logic [7:0]         expected_q, expected_d;
    logic [3:0]         match_cnt_q, match_cnt_d;
    logic [3:0]         miss_cnt_q, miss_cnt_d;
    logic               lock_q, lock_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

`ifdef LFSR_CHK_BITCNT_EN
    logic [CNT_W-1:0]   bit_err_count_q, bit_err_count_d;
    logic [7:0]         bit_diff;
    logic [3:0]         bit_pop;
    logic [CNT_W:0]     bit_sum;

    // Number of flipped bits in the current sample against the prediction
    always_comb begin
        bit_diff = i_data ^ expected_q;
        bit_pop  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            bit_pop = bit_pop + {3'd0, bit_diff[i]};
        end
        bit_sum = {1'b0, bit_err_count_q} + (CNT_W+1)'(bit_pop);
    end
`endif

    // Next-state, prediction and counter update for the current sample
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
`ifdef LFSR_CHK_BITCNT_EN
        bit_err_count_d = bit_err_count_q;
`endif

        if (i_soft_reset) begin
            // Resync wins over a coincident sample, which is dropped
            state_d     = ST_SEED;
            match_cnt_d = 4'd0;
            miss_cnt_d  = 4'd0;
            err_count_d = '0;
`ifdef LFSR_CHK_BITCNT_EN
            bit_err_count_d = '0;
`endif
        end else if (i_valid) begin
            case (state_q)
                ST_SEED: begin
                    // All-zero is outside the LFSR cycle, so it cannot seed
                    if (i_data != 8'd0) begin
                        expected_d  = lfsr_next(i_data);
                        match_cnt_d = 4'd0;
                        state_d     = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (i_data == expected_q) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        expected_d  = lfsr_next(i_data);
                        if (match_cnt_d == LOCK_CNT_L) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = 4'd0;
                        end
                    end else if (i_data != 8'd0) begin
                        expected_d  = lfsr_next(i_data);
                        match_cnt_d = 4'd0;
                    end else begin
                        state_d = ST_SEED;
                    end
                end
                ST_LOCKED: begin
                    // Free-run: corrupt words never disturb the prediction
                    expected_d = lfsr_next(expected_q);
                    if (i_data == expected_q) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        err_d      = 1'b1;
                        miss_cnt_d = miss_cnt_q + 4'd1;
                        if (err_count_q != {CNT_W{1'b1}}) begin
                            err_count_d = err_count_q + 1'b1;
                        end
`ifdef LFSR_CHK_BITCNT_EN
                        bit_err_count_d = bit_sum[CNT_W] ? {CNT_W{1'b1}} : bit_sum[CNT_W-1:0];
`endif
                        if (miss_cnt_d == UNLOCK_CNT_L) begin
                            state_d = ST_SEED;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEED;
                end
            endcase
        end

        lock_d = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_SEED;
            expected_q  <= 8'd0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
`ifdef LFSR_CHK_BITCNT_EN
            bit_err_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            lock_q      <= lock_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
`ifdef LFSR_CHK_BITCNT_EN
            bit_err_count_q <= bit_err_count_d;
`endif
        end
    end

    assign o_lock      = lock_q;
    assign o_err       = err_q;
    assign o_err_count = err_count_q;
`ifdef LFSR_CHK_BITCNT_EN
    assign o_bit_err_count = bit_err_count_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - Directed self-checking bench for lfsr_checker
module tb_lfsr_checker;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        i_soft_reset;

    logic        lock_a, err_a;
    logic [15:0] err_count_a;
    logic        lock_b, err_b;
    logic [3:0]  err_count_b;
`ifdef LFSR_CHK_BITCNT_EN
    logic [15:0] bit_count_a;
    logic [3:0]  bit_count_b;
`endif

    int checks = 0;
    int errors = 0;

    lfsr_checker u_dut (
        .clk            (clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_soft_reset   (i_soft_reset),
        .o_lock         (lock_a),
        .o_err          (err_a),
        .o_err_count    (err_count_a)
`ifdef LFSR_CHK_BITCNT_EN
        ,
        .o_bit_err_count(bit_count_a)
`endif
    );

    lfsr_checker #(.CNT_W(4)) u_dut_w4 (
        .clk            (clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .i_soft_reset   (i_soft_reset),
        .o_lock         (lock_b),
        .o_err          (err_b),
        .o_err_count    (err_count_b)
`ifdef LFSR_CHK_BITCNT_EN
        ,
        .o_bit_err_count(bit_count_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic sr);
        i_valid      = v;
        i_data       = d;
        i_soft_reset = sr;
        @(posedge clk);
        #1;
        i_valid      = 1'b0;
        i_soft_reset = 1'b0;
    endtask

    task automatic idle_gap(input string tag, input logic exp_lock);
        int n;
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 8'hFF, 1'b0);
            check_eq({tag, "_gap_err"}, 32'(err_a), 32'd0);
            check_eq({tag, "_gap_lock"}, 32'(lock_a), 32'(exp_lock));
        end
    endtask

    task automatic lock_up(input string tag);
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hAB, 1'b0);
        check_eq({tag, "_lock_pre"}, 32'(lock_a), 32'd0);
        drive(1'b1, 8'h57, 1'b0);
        check_eq({tag, "_lock"}, 32'(lock_a), 32'd1);
        check_eq({tag, "_lock_w4"}, 32'(lock_b), 32'd1);
    endtask

    function automatic logic [7:0] step_lfsr(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    initial begin
        logic [7:0] exp_word;
        i_rst        = 1'b1;
        i_valid      = 1'b0;
        i_data       = 8'h00;
        i_soft_reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        i_rst = 1'b0;
        check_eq("rst_lock", 32'(lock_a), 32'd0);
        check_eq("rst_err", 32'(err_a), 32'd0);
        check_eq("rst_cnt", 32'(err_count_a), 32'd0);
`ifdef LFSR_CHK_BITCNT_EN
        check_eq("rst_bitcnt", 32'(bit_count_a), 32'd0);
`endif

        // Zero in SEED is ignored, then lock with random idle gaps
        drive(1'b1, 8'h00, 1'b0);
        check_eq("zero_lock", 32'(lock_a), 32'd0);
        check_eq("zero_err", 32'(err_a), 32'd0);
        drive(1'b1, 8'hAA, 1'b0);
        idle_gap("g1", 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        idle_gap("g2", 1'b0);
        drive(1'b1, 8'hAB, 1'b0);
        check_eq("gap_prelock", 32'(lock_a), 32'd0);
        idle_gap("g3", 1'b0);
        drive(1'b1, 8'h57, 1'b0);
        check_eq("gap_lock", 32'(lock_a), 32'd1);
        check_eq("gap_err", 32'(err_a), 32'd0);
        check_eq("gap_cnt", 32'(err_count_a), 32'd0);
        idle_gap("g4", 1'b1);

        // Single error: 0xAE where 0xAF is predicted, then 0x5F still matches
        drive(1'b1, 8'hAE, 1'b0);
        check_eq("se_err", 32'(err_a), 32'd1);
        check_eq("se_cnt", 32'(err_count_a), 32'd1);
        check_eq("se_lock", 32'(lock_a), 32'd1);
`ifdef LFSR_CHK_BITCNT_EN
        check_eq("se_bitcnt", 32'(bit_count_a), 32'd1);
`endif
        drive(1'b1, 8'h5F, 1'b0);
        check_eq("se_err_off", 32'(err_a), 32'd0);
        check_eq("se_cnt_hold", 32'(err_count_a), 32'd1);
        check_eq("se_lock_hold", 32'(lock_a), 32'd1);

        // Second error (0xFF vs 0xBE), then 0x7C matches and clears the miss run
        drive(1'b1, 8'hFF, 1'b0);
        check_eq("e2_err", 32'(err_a), 32'd1);
        check_eq("e2_cnt", 32'(err_count_a), 32'd2);
`ifdef LFSR_CHK_BITCNT_EN
        check_eq("e2_bitcnt", 32'(bit_count_a), 32'd3);
`endif
        drive(1'b1, 8'h7C, 1'b0);
        check_eq("e2_lock", 32'(lock_a), 32'd1);
        check_eq("e2_err_off", 32'(err_a), 32'd0);

        // Soft reset together with a valid sample
        drive(1'b1, 8'hF9, 1'b1);
        check_eq("sr_lock", 32'(lock_a), 32'd0);
        check_eq("sr_cnt", 32'(err_count_a), 32'd0);
        check_eq("sr_err", 32'(err_a), 32'd0);
`ifdef LFSR_CHK_BITCNT_EN
        check_eq("sr_bitcnt", 32'(bit_count_a), 32'd0);
`endif
        lock_up("relock");

        // Loss of lock: three 0xFF against 0xAF, 0x5F, 0xBE
        drive(1'b1, 8'hFF, 1'b0);
        check_eq("ll1_err", 32'(err_a), 32'd1);
        check_eq("ll1_lock", 32'(lock_a), 32'd1);
        drive(1'b1, 8'hFF, 1'b0);
        check_eq("ll2_err", 32'(err_a), 32'd1);
        check_eq("ll2_lock", 32'(lock_a), 32'd1);
        drive(1'b1, 8'hFF, 1'b0);
        check_eq("ll3_err", 32'(err_a), 32'd1);
        check_eq("ll3_lock", 32'(lock_a), 32'd0);
        check_eq("ll3_cnt", 32'(err_count_a), 32'd3);
`ifdef LFSR_CHK_BITCNT_EN
        check_eq("ll3_bitcnt", 32'(bit_count_a), 32'd6);
`endif
        drive(1'b1, 8'hFF, 1'b0);
        check_eq("ll4_err", 32'(err_a), 32'd0);
        check_eq("ll4_cnt", 32'(err_count_a), 32'd3);

        // Saturation: 20 isolated single-bit errors while locked
        drive(1'b0, 8'h00, 1'b1);
        lock_up("sat");
        exp_word = 8'hAF;
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, exp_word ^ 8'h01, 1'b0);
            check_eq("sat_err", 32'(err_a), 32'd1);
            exp_word = step_lfsr(exp_word);
            drive(1'b1, exp_word, 1'b0);
            exp_word = step_lfsr(exp_word);
        end
        check_eq("sat_lock", 32'(lock_a), 32'd1);
        check_eq("sat_cnt16", 32'(err_count_a), 32'd20);
        check_eq("sat_cnt4", 32'(err_count_b), 32'd15);
`ifdef LFSR_CHK_BITCNT_EN
        check_eq("sat_bitcnt16", 32'(bit_count_a), 32'd20);
        check_eq("sat_bitcnt4", 32'(bit_count_b), 32'd15);
`endif

        // Hard reset mid-lock
        i_rst = 1'b1;
        drive(1'b1, exp_word, 1'b0);
        i_rst = 1'b0;
        check_eq("hr_lock", 32'(lock_a), 32'd0);
        check_eq("hr_cnt", 32'(err_count_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 8-bit LFSR pattern generator. It consumes the generator's per-cycle state word, self-synchronises by seeding from the incoming stream, and declares lock after a run of correct predictions. Once locked, it flags and counts mismatches, and it drops lock after repeated consecutive errors. It sits at the far end of a link or datapath under test, fed by the same `clk` domain.

## Interface
- `LOCK_CNT`, 3: consecutive correct predictions needed to declare lock (1..15).
- `UNLOCK_CNT`, 3: consecutive mismatches while locked that force loss of lock (1..15).
- `CNT_W`, 16: width of the error counters.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  qualifies `i_data` on this edge; samples with `i_valid=0` are ignored.
- `i_data`  in  8  received LFSR state word.
- `i_soft_reset`  in  1  synchronous resync: returns to SEED and clears the counters.
- `o_lock`  out  1  high while in LOCKED.
- `o_err`  out  1  one-cycle pulse per mismatched sample while locked.
- `o_err_count`  out  CNT_W  saturating count of mismatched samples while locked.
- `o_bit_err_count`  out  CNT_W  saturating count of mismatched bits (present only with `LFSR_CHK_BITCNT_EN`).

## Operation
- Step function: fb = s[7]^s[5]^s[4]^s[3]; next(s) = {s[6:0], fb}. The polynomial is x^8+x^6+x^5+x^4+1, identical to the generator.
- Reset (`i_rst`) values:
  - state SEED; `expected` = 0; match and miss counters = 0.
  - all outputs are 0.
- SEED state, on a valid sample:
  - Nonzero data: `expected` ← next(data), match counter ← 0, go to CHECK.
  - Zero data: stay in SEED. Zero is an illegal LFSR state and is never counted as an error.
- CHECK state, on a valid sample:
  - data == `expected`: increment the match counter; `expected` ← next(data). When the counter reaches `LOCK_CNT`, go to LOCKED and clear the miss counter.
  - Mismatch with nonzero data: reseed (`expected` ← next(data)), clear the match counter, stay in CHECK.
  - Mismatch with zero data: go to SEED.
  - No errors are counted in CHECK.
- LOCKED state, on a valid sample:
  - `expected` ← next(`expected`) on every sample. The checker free-runs and never reseeds from corrupt data.
  - Match: clear the miss counter.
  - Mismatch: pulse `o_err`, increment `o_err_count` (saturating at 2^CNT_W−1), and increment the miss counter. When the miss counter reaches `UNLOCK_CNT`, go to SEED.
- `i_soft_reset`:
  - Forces SEED and clears the match counter, miss counter, `o_err_count` and `o_bit_err_count`.
  - Takes priority over a simultaneous `i_valid`; that sample is discarded.
- `i_rst` has priority over everything.

## Timing
- All outputs are registered. `o_err` is high for exactly the one cycle following the edge that sampled the bad word.
- `o_err_count` updates on that same edge, so the new value is visible in the same cycle as `o_err`.
- `o_lock` rises on the edge that accepts the `LOCK_CNT`-th consecutive match. Minimum lock latency is `LOCK_CNT`+1 valid samples: one seed plus `LOCK_CNT` matches.
- `o_lock` falls on the edge that accepts the `UNLOCK_CNT`-th consecutive mismatch. That sample still pulses `o_err` and is counted.
- Gaps in `i_valid` do not advance `expected` and do not affect any counter.
- Counters hold at saturation; they do not wrap.
- A reset or soft reset mid-lock deasserts `o_lock` in the next cycle. The following valid sample is treated as a seed.

## Configuration
- `LFSR_CHK_BITCNT_EN` defined: `o_bit_err_count` exists. On each counted mismatch it adds popcount(data ^ `expected`), 1..8, saturating.
- `LFSR_CHK_BITCNT_EN` undefined: the port and the popcount logic are absent. All other behaviour is identical.

## Test plan
- Lock: `i_rst` pulse, then valid 0xAA, 0x55, 0xAB, 0x57 (`LOCK_CNT`=3) → `o_lock`=1 after the 4th edge; `o_err` never asserts; `o_err_count`=0.
- Single error: after lock, send 0xAE where 0xAF is expected, then 0x5F → one `o_err` pulse; `o_err_count`=1; `o_bit_err_count`=1; lock is held because 0x5F matches the free-running prediction.
- Loss of lock: after lock, send three valid 0xFF words with `UNLOCK_CNT`=3 → three `o_err` pulses; `o_err_count`=3; `o_lock` falls on the 3rd edge.
- Zero and gaps: send 0x00 in SEED → no state change. Interleave `i_valid`=0 cycles (random) during locked 0xAA→0x55→0xAB→0x57 → still locks; no errors.
- Soft reset: while locked with `o_err_count`=2, assert `i_soft_reset` together with `i_valid` for one cycle → `o_lock`=0 and both counters = 0 next cycle; re-lock follows the seed + 3 match rule.
- Saturation: with `CNT_W`=4, inject 20 isolated single errors while locked → `o_err_count` holds at 15.
